ysyx_220053_ifetch: RTL
=======================

# ysyx_220053_ifetch

Instruction-fetch sequencer sitting directly downstream of the PC register stage. Takes the current 64-bit PC, issues one 8-byte-aligned read per instruction on a valid/ready instruction-memory port and selects the 32-bit word. It hands the instruction plus its PC to decode on a valid/ready handshake, and pulses `fetch_done` so the PC register loads the next PC. Supports flush/redirect and flags misaligned or errored fetches.

## Interface
- `RESET_STATE`, IDLE: state entered on reset (no other legal value).
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-high.
- `pc`  in  64  current PC from the PC register; sampled only on entry to REQ.
- `flush`  in  1  redirect: the PC register already holds the new PC; discard in-flight work.
- `mem_req_valid`  out  1  read request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  64  `{req_pc[63:3], 3'b000}`.
- `mem_rsp_valid`  in  1  read data valid; memory always accepts responses (no rsp ready).
- `mem_rsp_data`  in  64  read data, little-endian doubleword.
- `mem_rsp_err`  in  1  access fault, qualified by `mem_rsp_valid`.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  64  PC of `inst`.
- `inst_fault`  out  1  1 = misaligned PC or memory error; `inst` = 0 when set.
- `fetch_done`  out  1  one-cycle pulse on `inst_valid & inst_ready & ~flush`.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Registers: `state`, `req_pc[63:0]`, `drop`, `inst_q`, `fault_q`.
- Reset (async): state=IDLE, `req_pc`=0, `drop`=0, `inst_q`=0, `fault_q`=0. All outputs 0.
- IDLE -> REQ on the first edge after reset release; `req_pc` <= `pc`.
- REQ, `req_pc[1:0]` != 0: `mem_req_valid`=0; next HOLD with `fault_q`=1, `inst_q`=0.
- REQ, aligned: `mem_req_valid`=1. `mem_req_addr` is constant while valid and not ready. On `mem_req_ready` -> WAIT.
- WAIT: on `mem_rsp_valid` with `drop`=0 -> HOLD. `inst_q` = `req_pc[2]` ? data[63:32] : data[31:0]; `fault_q` = `mem_rsp_err`; `inst_q` = 0 if err.
- WAIT: on `mem_rsp_valid` with `drop`=1 -> REQ, `drop` <= 0, `req_pc` <= `pc`; response discarded.
- HOLD: `inst_valid`=1, `inst`=`inst_q`, `inst_pc`=`req_pc`, `inst_fault`=`fault_q`. On `inst_ready` -> REQ, `req_pc` <= `pc` (already the next PC, loaded by the PC register on `fetch_done`).
- Flush handling:
  - IDLE: no effect.
  - REQ without handshake: request stays asserted with the same address (no retraction); `drop` <= 1.
  - REQ with handshake in the same cycle: -> WAIT with `drop`=1.
  - WAIT, no response: `drop` <= 1.
  - WAIT with `mem_rsp_valid` the same cycle: response discarded; -> REQ, `req_pc` <= `pc`.
  - HOLD: held instruction discarded; -> REQ, `req_pc` <= `pc`. Flush beats `inst_ready`; `fetch_done` stays 0.
- A REQ with `drop`=1 that completes its handshake enters WAIT still dropping; its response is discarded.
- `mem_rsp_valid` outside WAIT is a protocol error and is ignored.
- Exactly one request is outstanding at a time; no prefetch.

## Timing
- `req_pc` is registered. `mem_req_valid`/`mem_req_addr` are valid in the first cycle of REQ.
- Best case (ready in REQ, response the next cycle): REQ 1, WAIT 1, HOLD 1 → `inst_valid` 2 cycles after the first request cycle; 3 cycles per instruction.
- `inst`, `inst_pc` and `inst_fault` are stable while `inst_valid`=1 and `inst_ready`=0.
- Misaligned PC: `inst_valid` in the cycle after REQ, with no memory traffic.
- `fetch_done` is combinational from state/`inst_ready`/`flush` and is high for the single accepting cycle.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs 0. The memory side is reset by the same `rst`.

## Test plan
- Basic fetch: `pc`=0x80000000; ready=1; rsp data 0x00100073_00000413 one cycle after the handshake → `mem_req_addr`=0x80000000, `inst`=0x00000413, `inst_pc`=0x80000000, `fetch_done` pulses on `inst_ready`.
- Upper word and backpressure: `pc`=0x80000004; `mem_req_ready` low for 3 cycles, then `inst_ready` low for 2 cycles → addr held at 0x80000000 throughout; `inst`=0x00100073 stable until accepted.
- Misaligned: `pc`=0x80000002 → `mem_req_valid` never asserted; `inst_valid`=1, `inst_fault`=1, `inst`=0 in the cycle after REQ.
- Error response: rsp with `mem_rsp_err`=1 → `inst_fault`=1, `inst`=0.
- Flush in WAIT: pc 0x80000000 outstanding, `flush` with `pc`=0x80000100, response arrives 2 cycles later → no `inst_valid` for 0x80000000; next request addr 0x80000100.
- Flush with `inst_ready` in HOLD, plus async reset asserted mid-WAIT → `fetch_done`=0 and refetch from new pc; after reset all outputs 0 and state IDLE.

Source files
------------

// File: rtl/ysyx_220053_ifetch_if.sv
// ysyx_220053_ifetch_if
// Bus bundle between the fetch sequencer, instruction memory and decode.
//   mem_req_*  : read request, valid/ready, 8-byte aligned address
//   mem_rsp_*  : read response, valid only (memory side never stalls)
//   inst_*     : instruction hand-off to decode, valid/ready
//   fetch_done : pulse telling the PC register to advance
// master = fetch sequencer view, slave = memory/decode view.
interface ysyx_220053_ifetch_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;
  logic        fetch_done;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output inst_valid, inst, inst_pc, inst_fault, fetch_done,
    input  inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  inst_valid, inst, inst_pc, inst_fault, fetch_done,
    output inst_ready
  );
endinterface

// File: rtl/ysyx_220053_ifetch.sv
// ysyx_220053_ifetch
// Instruction-fetch sequencer: one outstanding 8-byte read per instruction,
// selects the 32-bit word addressed by pc[2], hands it to decode and pulses
// fetch_done so the PC register advances.
// Ports:
//   clk, rst : core clock, async active-high reset
//   pc       : current PC, captured on every entry to REQ
//   flush    : redirect; in-flight work is discarded
//   bus      : memory request/response and decode hand-off (master modport)
//
// state | meaning
// IDLE  | after reset; loads pc on the next edge
// REQ   | issuing read for req_pc (or detecting misalignment)
// WAIT  | request accepted, waiting for the response
// HOLD  | instruction (or fault) presented to decode
module ysyx_220053_ifetch (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [63:0]                 pc,
  input  logic                        flush,
  ysyx_220053_ifetch_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [63:0] req_pc, req_pc_d;
  logic        drop, drop_d;
  logic [31:0] inst_q, inst_q_d;
  logic        fault_q, fault_q_d;

  logic        misaligned;
  logic [31:0] rsp_word;

  assign misaligned = (req_pc[1:0] != 2'b00);
  assign rsp_word   = req_pc[2] ? bus.mem_rsp_data[63:32] : bus.mem_rsp_data[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req_pc  <= 64'd0;
      drop    <= 1'b0;
      inst_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_d;
      req_pc  <= req_pc_d;
      drop    <= drop_d;
      inst_q  <= inst_q_d;
      fault_q <= fault_q_d;
    end
  end

  always_comb begin
    state_d           = state;
    req_pc_d          = req_pc;
    drop_d            = drop;
    inst_q_d          = inst_q;
    fault_q_d         = fault_q;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = 64'd0;
    bus.inst_valid    = 1'b0;
    bus.inst          = 32'd0;
    bus.inst_pc       = 64'd0;
    bus.inst_fault    = 1'b0;
    bus.fetch_done    = 1'b0;

    case (state)
      IDLE: begin
        state_d  = REQ;
        req_pc_d = pc;
      end

      REQ: begin
        if (misaligned) begin
          // No memory traffic was issued, so a flush can simply re-sample pc.
          if (flush) begin
            req_pc_d = pc;
          end else begin
            state_d   = HOLD;
            fault_q_d = 1'b1;
            inst_q_d  = 32'd0;
          end
        end else begin
          // Once raised, the request is never retracted; a flush only marks
          // the eventual response for discard.
          bus.mem_req_valid = 1'b1;
          bus.mem_req_addr  = {req_pc[63:3], 3'b000};
          if (flush) drop_d = 1'b1;
          if (bus.mem_req_ready) state_d = WAIT;
        end
      end

      WAIT: begin
        if (bus.mem_rsp_valid) begin
          if (drop || flush) begin
            state_d  = REQ;
            drop_d   = 1'b0;
            req_pc_d = pc;
          end else begin
            state_d   = HOLD;
            fault_q_d = bus.mem_rsp_err;
            inst_q_d  = bus.mem_rsp_err ? 32'd0 : rsp_word;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end

      HOLD: begin
        bus.inst_valid = 1'b1;
        bus.inst       = inst_q;
        bus.inst_pc    = req_pc;
        bus.inst_fault = fault_q;
        // Flush wins over acceptance: the PC register already holds the
        // redirect target, so it must not be advanced.
        if (flush) begin
          state_d  = REQ;
          req_pc_d = pc;
        end else if (bus.inst_ready) begin
          bus.fetch_done = 1'b1;
          state_d        = REQ;
          req_pc_d       = pc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
